serial_word_loader: RTL and testbench

- Upstream feeder for the gated N-bit register stage.
- Deserialises an asynchronous, UART-style serial line (idle high, start bit, N data bits LSB first, optional parity, one stop bit) into an N-bit word.
- Presents the word on d and issues one load strobe ld_en per good frame, timed so the downstream register captures on the ld_en rising edge while clk is low.

---
 rtl/serial_word_loader.sv | 180 ++++++++++++++++++
 tb/tb_serial_word_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_loader.sv
// UART-style serial deserialiser feeding an N-bit gated register: one ld_en strobe per good frame.
// Optional even-parity bit and par_err reporting enabled by defining PARITY_EN.
`timescale 1ns/1ps
module serial_word_loader #(
    parameter int N   = 8,
    parameter int OVS = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         rx,
    output logic [N-1:0] d,
    output logic         ld_en,
    output logic         busy,
    output logic         frm_err,
    output logic         par_err
);

    localparam int OW = $clog2(OVS);
    localparam int BW = $clog2(N + 1);
    localparam logic [OW-1:0] OS_HALF  = OW'(OVS / 2 - 1);
    localparam logic [OW-1:0] OS_FULL  = OW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

`ifdef PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_LOAD} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_LOAD} state_t;
`endif

    state_t        r_state;
    logic          r_rx_meta;
    logic          r_rxs;
    logic          r_rxs_prev;
    logic [OW-1:0] r_os_cnt;
    logic [BW-1:0] r_bit_cnt;
    logic [N-1:0]  r_shift;
    logic [N-1:0]  r_d;
    logic          r_busy;
    logic          r_frm_err;
    logic          r_ld_en;
`ifdef PARITY_EN
    logic          r_par_bad;
    logic          r_par_err;
`endif

    logic w_fall;
    logic w_os_full;

    assign w_fall    = r_rxs_prev & ~r_rxs;
    assign w_os_full = (r_os_cnt == OS_FULL);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_rx_meta  <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_d        <= '0;
            r_busy     <= 1'b0;
            r_frm_err  <= 1'b0;
`ifdef PARITY_EN
            r_par_bad  <= 1'b0;
            r_par_err  <= 1'b0;
`endif
        end else begin
            r_rx_meta  <= rx;
            r_rxs      <= r_rx_meta;
            r_rxs_prev <= r_rxs;
            r_frm_err  <= 1'b0;
`ifdef PARITY_EN
            r_par_err  <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state  <= S_START;
                        r_os_cnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_os_cnt == OS_HALF) begin
                        r_os_cnt <= '0;
                        if (r_rxs) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= '0;
                        end
                    end else begin
                        r_os_cnt <= r_os_cnt + OW'(1);
                    end
                end
                S_DATA: begin
                    if (w_os_full) begin
                        r_os_cnt <= '0;
                        // LSB arrives first, so each new bit enters at the top and walks down
                        r_shift  <= {r_rxs, r_shift[N-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
`ifdef PARITY_EN
                            r_state   <= S_PARITY;
`else
                            r_state   <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end else begin
                        r_os_cnt <= r_os_cnt + OW'(1);
                    end
                end
`ifdef PARITY_EN
                S_PARITY: begin
                    if (w_os_full) begin
                        r_os_cnt  <= '0;
                        r_par_bad <= (^r_shift) ^ r_rxs;
                        r_state   <= S_STOP;
                    end else begin
                        r_os_cnt <= r_os_cnt + OW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_os_full) begin
                        r_os_cnt <= '0;
                        if (!r_rxs) begin
                            r_frm_err <= 1'b1;
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
`ifdef PARITY_EN
                        end else if (r_par_bad) begin
                            r_par_err <= 1'b1;
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
`endif
                        end else begin
                            r_d     <= r_shift;
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_os_cnt <= r_os_cnt + OW'(1);
                    end
                end
                S_LOAD: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Falling-edge flop: d settles half a cycle before the strobe rises while clk is low
    always_ff @(negedge clk or negedge clr) begin
        if (!clr) begin
            r_ld_en <= 1'b0;
        end else begin
            r_ld_en <= (r_state == S_LOAD);
        end
    end

    assign d       = r_d;
    assign ld_en   = r_ld_en;
    assign busy    = r_busy;
    assign frm_err = r_frm_err;
`ifdef PARITY_EN
    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_loader.sv
// Self-checking bench for serial_word_loader: directed frames plus random traffic against a frame-level model.
`timescale 1ns/1ps
module tb_serial_word_loader;

    localparam int N   = 8;
    localparam int OVS = 4;
`ifdef PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clr;
    logic         rx;
    logic [N-1:0] d;
    logic         ld_en;
    logic         busy;
    logic         frm_err;
    logic         par_err;

    int n_cmp = 0;
    int n_err = 0;
    int n_ld  = 0;
    int n_frm = 0;
    int n_par = 0;
    int exp_ld  = 0;
    int exp_frm = 0;
    int exp_par = 0;
    int busy_samples = 0;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] ld_log[$];
    logic [N-1:0] model_d = '0;
    logic         prev_ld = 1'b0;
    bit           armed   = 1'b0;
    time          t_rise  = 0;

    always #5 clk = ~clk;

    serial_word_loader #(.N(N), .OVS(OVS)) dut (
        .clk     (clk),
        .clr     (clr),
        .rx      (rx),
        .d       (d),
        .ld_en   (ld_en),
        .busy    (busy),
        .frm_err (frm_err),
        .par_err (par_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        wait_cyc(OVS);
    endtask

    // Frame-level model: a frame is good iff stop is high and (when enabled) parity is even.
    task automatic send_frame(input logic [N-1:0] w, input bit stop_ok, input bit par_ok);
        bit good;
        drive_bit(1'b0);
        for (int i = 0; i < N; i++) drive_bit(w[i]);
        if (PAR) drive_bit(par_ok ? ^w : ~(^w));
        good = stop_ok && (par_ok || !PAR);
        if (!stop_ok) exp_frm++;
        else if (!good) exp_par++;
        if (good) begin
            exp_q.push_back(w);
            exp_ld++;
        end
        drive_bit(stop_ok);
    endtask

    task automatic false_start();
        rx = 1'b0;
        wait_cyc(1);
        rx = 1'b1;
        wait_cyc(2 * OVS);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (armed && clr === 1'b1) begin
                if (ld_en === 1'b1) begin
                    chk("ld_single_sample", {31'd0, prev_ld}, 32'd0);
                    chk("ld_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) model_d = exp_q.pop_front();
                    ld_log.push_back(d);
                    n_ld++;
                end
                chk("d_model", {24'd0, d}, {24'd0, model_d});
                if (!PAR) chk("par_err_tied", {31'd0, par_err}, 32'd0);
                if (frm_err === 1'b1) n_frm++;
                if (par_err === 1'b1) n_par++;
                if (busy === 1'b1) busy_samples++;
                prev_ld = ld_en;
            end
        end
    end

    always @(posedge ld_en) begin
        if (armed && clr === 1'b1) begin
            chk("ld_rise_clk_low", {31'd0, clk}, 32'd0);
            t_rise = $time;
        end
    end

    always @(negedge ld_en) begin
        if (armed && clr === 1'b1) chk("ld_high_time", 32'($time - t_rise), 32'd10);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           l0, f0, p0;
        logic [N-1:0] w;
        bit           stop_ok, par_ok;

        clr = 1'b0;
        rx  = 1'b1;
        wait_cyc(3);
        chk("reset_d", {24'd0, d}, 32'd0);
        chk("reset_ld_en", {31'd0, ld_en}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_frm_err", {31'd0, frm_err}, 32'd0);
        chk("reset_par_err", {31'd0, par_err}, 32'd0);
        clr   = 1'b1;
        armed = 1'b1;
        wait_cyc(4);

        l0 = n_ld;
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_cyc(2 * OVS);
        chk("good_a5_d", {24'd0, d}, 32'hA5);
        chk("good_a5_ld_count", 32'(n_ld - l0), 32'd1);
        chk("good_a5_busy_low", {31'd0, busy}, 32'd0);
        chk("good_a5_no_frm", 32'(n_frm), 32'd0);

        busy_samples = 0;
        l0 = n_ld;
        false_start();
        chk("false_start_busy_cycles", 32'(busy_samples), 32'd2);
        chk("false_start_no_ld", 32'(n_ld - l0), 32'd0);
        chk("false_start_d", {24'd0, d}, 32'hA5);

        f0 = n_frm;
        l0 = n_ld;
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_cyc(40);
        chk("frm_err_pulses", 32'(n_frm - f0), 32'd1);
        chk("frm_err_no_ld", 32'(n_ld - l0), 32'd0);
        chk("frm_err_d_hold", {24'd0, d}, 32'hA5);
        chk("frm_err_no_retrigger", {31'd0, busy}, 32'd0);
        rx = 1'b1;
        wait_cyc(2 * OVS);

        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rx = 1'b1;
        wait_cyc(2);
        clr     = 1'b0;
        model_d = '0;
        exp_q.delete();
        #1;
        chk("midframe_reset_d", {24'd0, d}, 32'd0);
        chk("midframe_reset_busy", {31'd0, busy}, 32'd0);
        chk("midframe_reset_ld_en", {31'd0, ld_en}, 32'd0);
        @(negedge clk);
        #1;
        wait_cyc(2);
        clr = 1'b1;
        wait_cyc(4);
        l0 = n_ld;
        send_frame(8'h81, 1'b1, 1'b1);
        wait_cyc(2 * OVS);
        chk("after_reset_d", {24'd0, d}, 32'h81);
        chk("after_reset_ld_count", 32'(n_ld - l0), 32'd1);

        ld_log.delete();
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'h80, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        wait_cyc(2 * OVS);
        chk("b2b_ld_count", 32'(ld_log.size()), 32'd3);
        if (ld_log.size() == 3) begin
            chk("b2b_word0", {24'd0, ld_log[0]}, 32'h01);
            chk("b2b_word1", {24'd0, ld_log[1]}, 32'h80);
            chk("b2b_word2", {24'd0, ld_log[2]}, 32'hFF);
        end

`ifdef PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        wait_cyc(2 * OVS);
        chk("parity_good_d", {24'd0, d}, 32'h07);
        p0 = n_par;
        l0 = n_ld;
        send_frame(8'h07, 1'b1, 1'b0);
        wait_cyc(2 * OVS);
        chk("parity_bad_pulse", 32'(n_par - p0), 32'd1);
        chk("parity_bad_no_ld", 32'(n_ld - l0), 32'd0);
        chk("parity_bad_d_hold", {24'd0, d}, 32'h07);
`else
        p0 = 0;
`endif

        for (int k = 0; k < 40; k++) begin
            w       = N'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
            par_ok  = ($urandom_range(0, 5) != 0);
            send_frame(w, stop_ok, par_ok);
            if (!stop_ok) begin
                rx = 1'b1;
                wait_cyc(OVS * int'($urandom_range(1, 2)));
            end else begin
                wait_cyc(OVS * int'($urandom_range(0, 2)));
            end
            if ($urandom_range(0, 4) == 0) begin
                rx = 1'b1;
                wait_cyc(OVS);
                false_start();
            end
        end
        rx = 1'b1;
        wait_cyc(4 * OVS);
        chk("total_ld", 32'(n_ld), 32'(exp_ld));
        chk("total_frm", 32'(n_frm), 32'(exp_frm));
        chk("total_par", 32'(n_par), 32'(exp_par + p0 - p0));
        chk("expected_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("final_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
